tick_scheduler: RTL
===================

Name: tick_scheduler

Overview:
- Tick scheduler for the free-running 32-bit clock-divider count.
- Shares one divider count between NUM_CH consumers (VGA pixel enable, game-logic tick, animation, debounce).
- Each channel gets a one-cycle enable strobe on the rising edge of a programmable divider bit.
- A global RUN/PAUSED/STEP state machine gates all strobes, so game logic can be frozen and single-stepped.

Parameters:
- NUM_CH, 4, number of tick channels (1..8).
- DEFAULT_SEL, 5'd1, divider bit index loaded into every channel at reset (bit 1 = clk/4 = 25 MHz from 100 MHz).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- div_res  in  32  free-running divider count.
- cfg_we  in  1  configuration write strobe.
- cfg_ch  in  3  channel index for the write; indices >= NUM_CH are ignored.
- cfg_sel  in  5  divider bit index for the channel.
- cfg_en  in  1  channel enable.
- pause_req  in  1  request entry to PAUSED.
- resume_req  in  1  request entry to RUN.
- step_req  in  1  request a single step (honoured only in PAUSED).
- tick_o  out  NUM_CH  per-channel enable strobes.
- state_o  out  2  current state: 00 RUN, 01 PAUSED, 10 STEP.

Behaviour:
- Reset (clk/rst as already decided):
  - sel[ch]=DEFAULT_SEL, en[ch]=0, prev[ch]=1.
  - tick_o=0, state_o=RUN, step_done mask=0.
- Edge detection:
  - cur[ch] = div_res[sel[ch]].
  - edge[ch] = en[ch] & ~prev[ch] & cur[ch].
  - prev[ch] <= cur[ch] every cycle.
- Output timing: tick_o is registered. It is high for exactly one clk, in the cycle after the one in which div_res[sel] is first sampled as 1. Latency is 1 clk.
- Tick gating by state:
  - RUN: tick_o[ch] <= edge[ch].
  - PAUSED: tick_o = 0; edges are discarded, not queued.
  - STEP: tick_o[ch] <= edge[ch] & ~step_done[ch]; step_done[ch] is set when that channel ticks.
- Config write (cfg_we=1, cfg_ch<NUM_CH):
  - sel and en update at the clock edge.
  - prev[cfg_ch] <= div_res[cfg_sel], which blocks a spurious edge caused by the bit-index switch.
  - The written channel emits no tick in the write cycle.
  - Other channels are unaffected.
  - cfg_ch>=NUM_CH: no effect.
- FSM transitions, evaluated each clk:
  - RUN: pause_req -> PAUSED.
  - PAUSED:
    - resume_req -> RUN.
    - else step_req -> STEP, clearing step_done.
    - pause_req is ignored.
  - STEP:
    - resume_req -> RUN.
    - pause_req -> PAUSED (step aborted).
    - step_done covers all enabled channels -> PAUSED in the cycle after the last tick.
    - No channel enabled -> PAUSED next cycle.
- Simultaneous requests:
  - pause_req+resume_req in RUN: pause wins.
  - In PAUSED, resume beats step.
  - In STEP, resume beats pause.
- Disabling a channel mid-STEP removes it from the completion check immediately.
- rst mid-operation overrides everything, including cfg_we, in the same cycle.
- Wrap-around of div_res needs no special handling: the MSB 1->0 transition is not an edge.

Optional Feature:
- Macro: TICK_ACK_EN.
- Defined:
  - Adds input tick_ack[NUM_CH] and output overrun_o[NUM_CH].
  - tick_o[ch] becomes a level request: set on a gated edge, held until the cycle tick_ack[ch]=1 is sampled, then cleared next clk.
  - If a new gated edge arrives while the request is pending, the request stays high and sticky overrun_o[ch] is set.
  - overrun_o[ch] clears only on rst or a cfg write to that channel.
  - For STEP completion, a channel is done when its tick is acknowledged.
- Undefined: one-cycle strobes as above; no ack/overrun ports.

Decomposition:
- Package tick_sched_pkg holds:
  - state encoding constants ST_RUN/ST_PAUSED/ST_STEP;
  - SEL_W=5;
  - CH_IDX_W=3.
- One natural sub-module, tick_channel: per-channel sel/en/prev registers, edge detection, tick register and (under TICK_ACK_EN) ack/overrun logic.
- The top level holds the FSM and step_done, and instantiates NUM_CH tick_channels.

Test Plan:
- Reset, write ch0 sel=1 en=1, run div_res counter from 0 -> tick_o[0] pulses every 4 clk, one clk after div_res[1] goes 0->1; other bits stay 0.
- Ch1 sel=3, then rewrite sel=0 while div_res[0]=1 and div_res[3]=0 -> no tick in the write cycle or the next; next tick on the following div_res[0] rise.
- pause_req during RUN with ch0,ch1 enabled -> state_o=01 next clk; tick_o stays 0 for 100 clk.
- In PAUSED, step_req with ch0 sel=1 and ch1 sel=4 -> exactly one tick each, then state_o returns to 01 the clk after ch1's tick.
- pause_req and resume_req asserted together in RUN -> PAUSED; in PAUSED, step_req with resume_req -> RUN.
- TICK_ACK_EN, ch0 sel=1, ack withheld for 10 clk -> tick_o[0] held high, overrun_o[0]=1 after the second edge; ack -> tick_o[0]=0 next clk, overrun_o[0] stays 1.

Source files
------------

// File: rtl/tick_sched_pkg.sv
// Shared constants for the tick scheduler: FSM state codes and field widths.
package tick_sched_pkg;

  localparam int unsigned SEL_W    = 5;
  localparam int unsigned CH_IDX_W = 3;

  localparam logic [1:0] ST_RUN    = 2'b00;
  localparam logic [1:0] ST_PAUSED = 2'b01;
  localparam logic [1:0] ST_STEP   = 2'b10;

endpackage

// File: rtl/tick_channel.sv
// One tick channel: selects a divider bit, detects its rising edge and registers the strobe.
// With TICK_ACK_EN defined the strobe becomes a request held until acknowledged.
module tick_channel
  import tick_sched_pkg::*;
#(
  parameter logic [SEL_W-1:0] DEFAULT_SEL = 5'd1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      div_res_i,
  input  logic             cfg_wr_i,
  input  logic [SEL_W-1:0] cfg_sel_i,
  input  logic             cfg_en_i,
  input  logic             gate_i,
`ifdef TICK_ACK_EN
  input  logic             tick_ack_i,
  output logic             overrun_o,
`endif
  output logic             en_o,
  output logic             done_o,
  output logic             tick_o
);

  logic [SEL_W-1:0] sel_q;
  logic             en_q;
  logic             prev_q;
  logic             tick_q;
  logic             cur_bit;
  logic             edge_det;
  logic             fire;

  assign cur_bit  = div_res_i[sel_q];
  assign edge_det = en_q & ~prev_q & cur_bit;
  // A channel being rewritten never fires in the write cycle.
  assign fire     = edge_det & gate_i & ~cfg_wr_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q  <= DEFAULT_SEL;
      en_q   <= 1'b0;
      prev_q <= 1'b1;
    end else begin
      // Seed prev from the new bit so the index switch itself is not seen as an edge.
      prev_q <= cfg_wr_i ? div_res_i[cfg_sel_i] : cur_bit;
      if (cfg_wr_i) begin
        sel_q <= cfg_sel_i;
        en_q  <= cfg_en_i;
      end
    end
  end

`ifdef TICK_ACK_EN
  logic overrun_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      tick_q <= fire | (tick_q & ~tick_ack_i);
      if (cfg_wr_i) begin
        overrun_q <= 1'b0;
      end else if (fire && tick_q && !tick_ack_i) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign overrun_o = overrun_q;
  assign done_o    = tick_q & tick_ack_i;
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= fire;
    end
  end

  assign done_o = fire;
`endif

  assign en_o   = en_q;
  assign tick_o = tick_q;

endmodule

// File: rtl/tick_scheduler.sv
// Tick scheduler: NUM_CH edge-strobe channels sharing one divider count, gated by RUN/PAUSED/STEP.
// Optional TICK_ACK_EN turns strobes into acknowledged level requests with sticky overrun flags.
module tick_scheduler
  import tick_sched_pkg::*;
#(
  parameter int unsigned      NUM_CH      = 4,
  parameter logic [SEL_W-1:0] DEFAULT_SEL = 5'd1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         div_res,
  input  logic                cfg_we,
  input  logic [CH_IDX_W-1:0] cfg_ch,
  input  logic [SEL_W-1:0]    cfg_sel,
  input  logic                cfg_en,
  input  logic                pause_req,
  input  logic                resume_req,
  input  logic                step_req,
`ifdef TICK_ACK_EN
  input  logic [NUM_CH-1:0]   tick_ack,
  output logic [NUM_CH-1:0]   overrun_o,
`endif
  output logic [NUM_CH-1:0]   tick_o,
  output logic [1:0]          state_o
);

  logic [1:0]        state_q, state_d;
  logic [NUM_CH-1:0] step_done_q, step_done_d;
  logic [NUM_CH-1:0] gate;
  logic [NUM_CH-1:0] cfg_wr;
  logic [NUM_CH-1:0] ch_en;
  logic [NUM_CH-1:0] ch_done;
  logic              step_complete;

  // Disabled channels count as done, so an empty step ends immediately.
  assign step_complete = &(step_done_q | ~ch_en);

  always_comb begin
    case (state_q)
      ST_RUN:  gate = '1;
      ST_STEP: gate = ~step_done_q;
      default: gate = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    step_done_d = step_done_q | ch_done;
    case (state_q)
      ST_RUN: begin
        if (pause_req) begin
          state_d = ST_PAUSED;
        end
      end
      ST_PAUSED: begin
        if (resume_req) begin
          state_d = ST_RUN;
        end else if (step_req) begin
          state_d     = ST_STEP;
          step_done_d = '0;
        end
      end
      ST_STEP: begin
        if (resume_req) begin
          state_d = ST_RUN;
        end else if (pause_req || step_complete) begin
          state_d = ST_PAUSED;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      step_done_q <= '0;
    end else begin
      state_q     <= state_d;
      step_done_q <= step_done_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign cfg_wr[i] = cfg_we && (cfg_ch == CH_IDX_W'(i));

    tick_channel #(
      .DEFAULT_SEL (DEFAULT_SEL)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .div_res_i  (div_res),
      .cfg_wr_i   (cfg_wr[i]),
      .cfg_sel_i  (cfg_sel),
      .cfg_en_i   (cfg_en),
      .gate_i     (gate[i]),
`ifdef TICK_ACK_EN
      .tick_ack_i (tick_ack[i]),
      .overrun_o  (overrun_o[i]),
`endif
      .en_o       (ch_en[i]),
      .done_o     (ch_done[i]),
      .tick_o     (tick_o[i])
    );
  end

  assign state_o = state_q;

endmodule
